// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-master (IFU, LSU) to one-slave memory-port arbiter. It holds
//            one outstanding transaction at a time, uses round-robin on ties,
//            routes each response back to its owner, and times out a silent
//            memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int WIDTH   = 32,
   parameter int MASKW   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifu_req_valid,
   output logic             ifu_req_ready,
   input  logic [WIDTH-1:0] ifu_addr,
   output logic             ifu_resp_valid,
   output logic [WIDTH-1:0] ifu_rdata,
   input  logic             lsu_req_valid,
   output logic             lsu_req_ready,
   input  logic [WIDTH-1:0] lsu_addr,
   input  logic             lsu_wen,
   input  logic [WIDTH-1:0] lsu_wdata,
   input  logic [MASKW-1:0] lsu_wmask,
   output logic             lsu_resp_valid,
   output logic [WIDTH-1:0] lsu_rdata,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_wen,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [MASKW-1:0] mem_wmask,
   input  logic             mem_resp_valid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             busy,
   output logic             err
);

   localparam logic [15:0] c_timeout = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_owner_lsu;   // owner of the transaction in flight
   logic             r_last_lsu;    // most recent grant, for round-robin
   logic [15:0]      r_cnt;
   logic [WIDTH-1:0] r_addr;
   logic             r_wen;
   logic [WIDTH-1:0] r_wdata;
   logic [MASKW-1:0] r_wmask;
   logic             r_err;

   logic w_gnt_ifu;
   logic w_gnt_lsu;
   logic w_resp;      // genuine memory response in WAIT
   logic w_timeout;   // forced error response in WAIT
   logic w_stray;     // response arriving outside WAIT

   // Next-state, grant and response decode; everything is suppressed while rst is high
   always_comb begin
      w_next    = r_state;
      w_gnt_ifu = 1'b0;
      w_gnt_lsu = 1'b0;
      w_resp    = 1'b0;
      w_timeout = 1'b0;
      w_stray   = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               // On a tie the master that did not win last time is granted
               w_gnt_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
               w_gnt_ifu = ifu_req_valid && (!lsu_req_valid ||  r_last_lsu);
               w_stray   = mem_resp_valid;
               if (w_gnt_lsu || w_gnt_ifu) begin
                  w_next = S_ISSUE;
               end
            end
            S_ISSUE: begin
               w_stray = mem_resp_valid;
               if (mem_req_ready) begin
                  w_next = S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  w_resp = 1'b1;
                  w_next = S_IDLE;
               end else if (r_cnt == c_timeout) begin
                  w_timeout = 1'b1;
                  w_next    = S_IDLE;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // State register, request latch, wait counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_owner_lsu <= 1'b0;
         r_last_lsu  <= 1'b0;
         r_cnt       <= 16'd0;
         r_addr      <= '0;
         r_wen       <= 1'b0;
         r_wdata     <= '0;
         r_wmask     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_gnt_lsu) begin
            r_owner_lsu <= 1'b1;
            r_last_lsu  <= 1'b1;
            r_addr      <= lsu_addr;
            r_wen       <= lsu_wen;
            r_wdata     <= lsu_wdata;
            r_wmask     <= lsu_wmask;
         end else if (w_gnt_ifu) begin
            r_owner_lsu <= 1'b0;
            r_last_lsu  <= 1'b0;
            r_addr      <= ifu_addr;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
         end
         if (r_state == S_ISSUE && mem_req_ready) begin
            r_cnt <= 16'd0;
         end else if (r_state == S_WAIT && !w_resp && !w_timeout) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_stray || w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   // Responses go only to the owner; rdata is zero unless a real response is forwarded
   always_comb begin
      ifu_req_ready  = w_gnt_ifu;
      lsu_req_ready  = w_gnt_lsu;
      ifu_resp_valid = (w_resp || w_timeout) && !r_owner_lsu;
      lsu_resp_valid = (w_resp || w_timeout) &&  r_owner_lsu;
      ifu_rdata      = (w_resp && !r_owner_lsu) ? mem_rdata : '0;
      lsu_rdata      = (w_resp &&  r_owner_lsu) ? mem_rdata : '0;
      mem_req_valid  = (r_state == S_ISSUE);
      mem_addr       = r_addr;
      mem_wen        = r_wen;
      mem_wdata      = r_wdata;
      mem_wmask      = r_wmask;
      busy           = (r_state != S_IDLE);
      err            = r_err;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wmask, mem_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy, err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        lsu;
      logic [31:0] data;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   mem_arbiter #(.WIDTH(32), .MASKW(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Every response pulse is matched against the oldest expected response
   always @(negedge clk) begin
      if (ifu_resp_valid || lsu_resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_owner_lsu", lsu_resp_valid, e.lsu);
            chk("resp_owner_ifu", ifu_resp_valid, !e.lsu);
            chk("resp_data", e.lsu ? lsu_rdata : ifu_rdata, e.data);
            chk("resp_nonowner_data", e.lsu ? ifu_rdata : lsu_rdata, 0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      ifu_req_valid = 0; ifu_addr = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("reset_outputs", {ifu_req_ready, lsu_req_ready, mem_req_valid, busy, err, mem_wen}, 0);
      chk("reset_fields", {mem_addr, mem_wdata}, 0);

      // IFU fetch, minimum latency
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
      #1;
      chk("t1_ifu_ready", ifu_req_ready, 1);
      chk("t1_lsu_ready", lsu_req_ready, 0);
      q.push_back('{lsu: 1'b0, data: 32'h0000_0413});
      step();
      ifu_req_valid = 0;
      #1;
      chk("t1_mem_req_valid", mem_req_valid, 1);
      chk("t1_mem_addr", mem_addr, 32'h8000_0000);
      chk("t1_mem_wen", mem_wen, 0);
      chk("t1_ready_busy", ifu_req_ready, 0);
      step();
      mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
      #1;
      chk("t1_ifu_resp", ifu_resp_valid, 1);
      step();
      mem_resp_valid = 0; mem_rdata = 0;
      #1;
      chk("t1_busy_done", busy, 0);

      // LSU write with three stall cycles in ISSUE
      lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; mem_req_ready = 0;
      #1;
      chk("t2_lsu_ready", lsu_req_ready, 1);
      q.push_back('{lsu: 1'b1, data: 32'h1234_5678});
      step();
      lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_wen = 0;
      for (int i = 0; i < 4; i++) begin
         mem_req_ready = (i == 3);
         #1;
         chk("t2_issue_valid", mem_req_valid, 1);
         chk("t2_issue_fields", {mem_addr, mem_wdata, mem_wmask, mem_wen},
             {32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 1'b1});
         step();
      end
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
      #1;
      chk("t2_lsu_resp", {lsu_resp_valid, ifu_resp_valid}, 2'b10);
      step();
      mem_resp_valid = 0; mem_rdata = 0;
      #1;
      chk("t2_no_repeat", {lsu_resp_valid, ifu_resp_valid, busy}, 0);

      // Round-robin with both masters always requesting, starting from reset
      do_reset();
      ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
      lsu_req_valid = 1; lsu_addr = 32'h0000_2000; lsu_wen = 0;
      mem_req_ready = 1;
      for (int k = 0; k < 4; k++) begin
         logic        exp_lsu;
         logic [31:0] d;
         exp_lsu = (k % 2 == 0);
         d = 32'hA000_0000 + 32'(k);
         #1;
         chk("t3_grant_lsu", lsu_req_ready, exp_lsu);
         chk("t3_grant_ifu", ifu_req_ready, !exp_lsu);
         q.push_back('{lsu: exp_lsu, data: d});
         step();
         chk("t3_mem_addr", mem_addr, exp_lsu ? 32'h0000_2000 : 32'h0000_1000);
         step();
         mem_resp_valid = 1; mem_rdata = d;
         step();
         mem_resp_valid = 0; mem_rdata = 0;
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      #1;
      chk("t3_err_clear", err, 0);

      // Timeout: memory accepts but never answers
      step();
      ifu_req_valid = 1; ifu_addr = 32'h0000_3000; mem_req_ready = 1;
      step();
      ifu_req_valid = 0;
      step();
      mem_req_ready = 0;
      for (int w = 0; w < 4; w++) begin
         #1;
         chk("t4_no_early_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
         step();
      end
      q.push_back('{lsu: 1'b0, data: 32'h0});
      #1;
      chk("t4_timeout_resp", ifu_resp_valid, 1);
      chk("t4_timeout_rdata", ifu_rdata, 0);
      step();
      chk("t4_err_set", err, 1);
      chk("t4_idle", busy, 0);
      lsu_req_valid = 1; lsu_addr = 32'h0000_4000; mem_req_ready = 1;
      #1;
      chk("t4_next_grant", lsu_req_ready, 1);
      q.push_back('{lsu: 1'b1, data: 32'h5555_AAAA});
      step();
      lsu_req_valid = 0;
      step();
      mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA;
      step();
      mem_resp_valid = 0; mem_rdata = 0;
      chk("t4_err_sticky", err, 1);

      // Stray response in IDLE
      do_reset();
      #1;
      chk("t5_err_after_rst", err, 0);
      mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("t5_no_pulse", {ifu_resp_valid, lsu_resp_valid}, 0);
      step();
      mem_resp_valid = 0; mem_rdata = 0;
      chk("t5_err", err, 1);

      // Reset while waiting for a response
      do_reset();
      lsu_req_valid = 1; lsu_addr = 32'h0000_5000; lsu_wen = 1; lsu_wdata = 32'h0BAD_F00D;
      lsu_wmask = 8'hFF; mem_req_ready = 1;
      step();
      lsu_req_valid = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      step();
      chk("t6_in_wait", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_req_ready = 0;
      #1;
      chk("t6_outputs_zero", {busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid, err, mem_wen}, 0);
      chk("t6_fields_zero", {mem_addr, mem_wdata, mem_wmask}, 0);
      mem_resp_valid = 1; mem_rdata = 32'h7777_7777;
      #1;
      chk("t6_late_no_pulse", {ifu_resp_valid, lsu_resp_valid}, 0);
      step();
      mem_resp_valid = 0; mem_rdata = 0;
      chk("t6_late_err", err, 1);

      step();
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
